// File: rtl/timer_pkg.sv
// timer_pkg: shared FSM state encoding for countdown_timer
package timer_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control/status bundle; master drives tick/load/load_val/start/pause/auto_reload, slave returns out/busy/tc
interface countdown_timer_if #(parameter int WIDTH = 4);
    logic             tick;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic             auto_reload;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             tc;
    modport master (output tick, load, load_val, start, pause, auto_reload, input out, busy, tc);
    modport slave  (input tick, load, load_val, start, pause, auto_reload, output out, busy, tc);
endinterface

// File: rtl/down_counter_core.sv
// down_counter_core: count register; ports clk, rst, ld/ld_val (load), dec (saturating decrement), cnt (registered count)
module down_counter_core #(parameter int WIDTH = 4) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt
);
    always_ff @(posedge clk)
        cnt <= rst ? '0 : ld ? ld_val : (dec && cnt != '0) ? cnt - WIDTH'(1) : cnt;
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with pause/auto-reload FSM; ports clk, rst, bus (countdown_timer_if.slave)
module countdown_timer
    import timer_pkg::*;
#(parameter int WIDTH = 4) (
    input logic              clk,
    input logic              rst,
    countdown_timer_if.slave bus
);
    state_t           state;
    logic [WIDTH-1:0] reload_reg, ld_val, cnt;
    logic             ld, dec, term, tc;
    assign term = state == RUN && !bus.load && !bus.pause && bus.tick && cnt == WIDTH'(1);
    always_comb begin
        ld     = bus.load || (term && bus.auto_reload) ||
                 (state == DONE && !bus.pause && bus.start && reload_reg != '0);
        ld_val = bus.load ? bus.load_val : reload_reg;
        dec    = state == RUN && !bus.load && !bus.pause && bus.tick && !(term && bus.auto_reload);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            reload_reg <= '0;
            tc         <= 1'b0;
        end else begin
            tc <= term;
            if (bus.load) begin
                reload_reg <= bus.load_val;
                state      <= IDLE;
            end else begin
                case (state)
                    IDLE:  state <= (!bus.pause && bus.start && cnt != '0) ? RUN : IDLE;
                    RUN:   state <= bus.pause ? PAUSE : (term && !bus.auto_reload) ? DONE : RUN;
                    PAUSE: state <= (!bus.pause && bus.start) ? RUN : PAUSE;
                    DONE:  state <= (!bus.pause && bus.start) ? (reload_reg != '0 ? RUN : IDLE) : DONE;
                endcase
            end
        end
    end
    down_counter_core #(.WIDTH(WIDTH)) core (
        .clk    (clk),
        .rst    (rst),
        .ld     (ld),
        .ld_val (ld_val),
        .dec    (dec),
        .cnt    (cnt)
    );
    assign bus.out  = cnt;
    assign bus.busy = state == RUN || state == PAUSE;
    assign bus.tc   = tc;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: table-driven and directed-sequence checks of countdown_timer
module tb_countdown_timer;
    localparam logic I = 1'b1, O = 1'b0;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    countdown_timer_if #(.WIDTH(4)) bus ();
    countdown_timer #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic       r, l;
        logic [3:0] lv;
        logic       s, p, t, a;
        logic [3:0] eo;
        logic       eb, et;
    } vec_t;
    vec_t tbl [26];
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", n, act, exp);
        end
    endtask
    task automatic chk_all(input string n, input logic [3:0] eo, input logic eb, input logic et);
        chk({n, ".out"}, 32'(bus.out), 32'(eo));
        chk({n, ".busy"}, 32'(bus.busy), 32'(eb));
        chk({n, ".tc"}, 32'(bus.tc), 32'(et));
    endtask
    task automatic cyc(input logic r, input logic l, input logic [3:0] lv,
                       input logic s, input logic p, input logic t, input logic a);
        @(negedge clk);
        rst = r; bus.load = l; bus.load_val = lv;
        bus.start = s; bus.pause = p; bus.tick = t; bus.auto_reload = a;
        @(posedge clk);
        #1;
    endtask
    initial begin
        int m;
        logic t;
        bus.tick = O; bus.load = O; bus.load_val = 4'd0;
        bus.start = O; bus.pause = O; bus.auto_reload = O;
        //          r  l  lv    s  p  t  a  out   busy tc
        tbl[0]  = '{I, O, 4'd0, O, O, O, O, 4'd0, O, O};
        tbl[1]  = '{O, I, 4'd5, O, O, O, O, 4'd5, O, O};
        tbl[2]  = '{O, O, 4'd0, I, O, I, O, 4'd5, I, O};
        tbl[3]  = '{O, O, 4'd0, O, O, I, O, 4'd4, I, O};
        tbl[4]  = '{O, O, 4'd0, O, O, I, O, 4'd3, I, O};
        tbl[5]  = '{O, O, 4'd0, O, O, I, O, 4'd2, I, O};
        tbl[6]  = '{O, O, 4'd0, O, O, I, O, 4'd1, I, O};
        tbl[7]  = '{O, O, 4'd0, O, O, I, O, 4'd0, O, I};
        tbl[8]  = '{O, O, 4'd0, O, O, I, O, 4'd0, O, O};
        tbl[9]  = '{O, O, 4'd0, I, O, O, O, 4'd5, I, O};
        tbl[10] = '{O, O, 4'd0, O, O, I, O, 4'd4, I, O};
        tbl[11] = '{O, O, 4'd0, O, O, I, O, 4'd3, I, O};
        tbl[12] = '{O, I, 4'd7, I, I, I, O, 4'd7, O, O};
        tbl[13] = '{O, I, 4'd0, O, O, O, O, 4'd0, O, O};
        tbl[14] = '{O, O, 4'd0, I, O, I, O, 4'd0, O, O};
        tbl[15] = '{O, O, 4'd0, O, O, I, O, 4'd0, O, O};
        tbl[16] = '{O, I, 4'd3, O, O, O, O, 4'd3, O, O};
        tbl[17] = '{O, O, 4'd0, I, O, O, O, 4'd3, I, O};
        tbl[18] = '{O, O, 4'd0, O, O, I, O, 4'd2, I, O};
        tbl[19] = '{I, O, 4'd0, O, O, I, O, 4'd0, O, O};
        tbl[20] = '{O, O, 4'd0, I, O, I, O, 4'd0, O, O};
        tbl[21] = '{O, O, 4'd0, O, O, I, O, 4'd0, O, O};
        tbl[22] = '{O, I, 4'd2, O, O, O, O, 4'd2, O, O};
        tbl[23] = '{O, O, 4'd0, I, O, I, O, 4'd2, I, O};
        tbl[24] = '{O, O, 4'd0, O, O, I, O, 4'd1, I, O};
        tbl[25] = '{O, I, 4'd4, O, O, I, O, 4'd4, O, O};
        for (int i = 0; i < 26; i++) begin
            cyc(tbl[i].r, tbl[i].l, tbl[i].lv, tbl[i].s, tbl[i].p, tbl[i].t, tbl[i].a);
            chk_all($sformatf("vec%0d", i), tbl[i].eo, tbl[i].eb, tbl[i].et);
        end
        // auto-reload period 3
        cyc(I, O, 4'd0, O, O, O, O);
        cyc(O, I, 4'd3, O, O, O, I);
        cyc(O, O, 4'd0, I, O, I, I);
        chk_all("ar_start", 4'd3, I, O);
        for (int k = 1; k <= 9; k++) begin
            cyc(O, O, 4'd0, O, O, I, I);
            chk_all($sformatf("ar%0d", k), 4'(3 - (k % 3)), I, (k % 3) == 0);
        end
        // auto-reload with reload value 1 pulses tc every tick
        cyc(O, I, 4'd1, O, O, O, I);
        cyc(O, O, 4'd0, I, O, I, I);
        chk_all("ar1_start", 4'd1, I, O);
        for (int k = 0; k < 4; k++) begin
            cyc(O, O, 4'd0, O, O, I, I);
            chk_all($sformatf("ar1_%0d", k), 4'd1, I, I);
        end
        // pause at 6 for four ticking cycles, then resume
        cyc(O, I, 4'd9, O, O, O, O);
        cyc(O, O, 4'd0, I, O, O, O);
        for (int k = 0; k < 3; k++) cyc(O, O, 4'd0, O, O, I, O);
        chk_all("pz_pre", 4'd6, I, O);
        for (int k = 0; k < 4; k++) begin
            cyc(O, O, 4'd0, O, I, I, O);
            chk_all($sformatf("pz_hold%0d", k), 4'd6, I, O);
        end
        cyc(O, O, 4'd0, I, O, I, O);
        chk_all("pz_resume", 4'd6, I, O);
        cyc(O, O, 4'd0, O, O, I, O);
        chk_all("pz_dec", 4'd5, I, O);
        // tick every third cycle
        cyc(I, O, 4'd0, O, O, O, O);
        cyc(O, I, 4'd4, O, O, O, O);
        cyc(O, O, 4'd0, I, O, O, O);
        m = 4;
        for (int k = 0; k < 12; k++) begin
            t = (k % 3) == 2;
            cyc(O, O, 4'd0, O, O, t, O);
            if (t && m > 0) m--;
            chk_all($sformatf("tg%0d", k), 4'(m), m != 0, t && m == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
